// File: rtl/cache_read_sched_pkg.sv
// Shared definitions for the packet-cache read scheduler.
//   state_e : scheduler FSM encoding (IDLE=0, ISSUE=1, WAIT_EOP=2)
//   ID_W    : cache ID width
//   CNT_W   : per-queue occupancy field width on the count bus
//   PRI_W   : descriptor priority field width
package cache_read_sched_pkg;

  localparam int ID_W  = 8;
  localparam int CNT_W = 5;
  localparam int PRI_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_EOP = 2'd2
  } state_e;

endpackage

// File: rtl/cache_read_sched_if.sv
// Bus bundle between the lookup stage / cache read port and the read scheduler.
//   in_desc_wr/id/pri : descriptor push from lookup
//   in_q_enable       : per-queue issue enable
//   in_tx_ready       : downstream can take a full packet
//   in_cache_eop      : last word of current packet from the cache
//   out_cache_id/_wr  : read request to the cache
//   out_q_count       : packed per-queue occupancy, 5 bits per queue
//   out_busy, out_issue_cnt, out_ovf_err, out_timeout_err : status
// Modports: slave = scheduler side, master = driver side.
interface cache_read_sched_if
  import cache_read_sched_pkg::*;
#(
  parameter int NQ = 4
) ();

  logic                  in_desc_wr;
  logic [ID_W-1:0]       in_desc_id;
  logic [PRI_W-1:0]      in_desc_pri;
  logic [NQ-1:0]         in_q_enable;
  logic                  in_tx_ready;
  logic                  in_cache_eop;
  logic [ID_W-1:0]       out_cache_id;
  logic                  out_cache_id_wr;
  logic [NQ*CNT_W-1:0]   out_q_count;
  logic                  out_busy;
  logic [31:0]           out_issue_cnt;
  logic                  out_ovf_err;
  logic                  out_timeout_err;

  modport slave (
    input  in_desc_wr, in_desc_id, in_desc_pri, in_q_enable, in_tx_ready, in_cache_eop,
    output out_cache_id, out_cache_id_wr, out_q_count, out_busy, out_issue_cnt,
           out_ovf_err, out_timeout_err
  );

  modport master (
    output in_desc_wr, in_desc_id, in_desc_pri, in_q_enable, in_tx_ready, in_cache_eop,
    input  out_cache_id, out_cache_id_wr, out_q_count, out_busy, out_issue_cnt,
           out_ovf_err, out_timeout_err
  );

endinterface

// File: rtl/sched_id_fifo.sv
// Synchronous FIFO holding cache IDs for one priority queue.
//   clk, rst  : clock, synchronous active-high reset (pointers/count only)
//   wr_i      : push wr_data_i (dropped when full unless popped same cycle)
//   rd_i      : pop head (ignored when empty)
//   rd_data_o : current head entry
//   full_o, empty_o, count_o : occupancy status, count is log2(DEPTH)+1 bits
module sched_id_fifo
  import cache_read_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_i,
  input  logic [ID_W-1:0]              wr_data_i,
  input  logic                         rd_i,
  output logic [ID_W-1:0]              rd_data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int FC_W  = PTR_W + 1;

  logic [ID_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FC_W-1:0]  count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == FC_W'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot a full-queue write needs.
  assign do_rd = rd_i && !empty_o;
  assign do_wr = wr_i && (!full_o || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/cache_read_sched.sv
// Packet-cache read scheduler: per-priority ID queues, strict-priority pick,
// one outstanding cache read at a time, bounded wait for end-of-packet.
//   clk, rst  : clock, synchronous active-high reset
//   sched_io  : cache_read_sched_if.slave bundle (descriptor input, queue
//               enables, tx ready, cache eop in; cache read request, queue
//               counts, busy, issue counter, sticky error flags out)
module cache_read_sched
  import cache_read_sched_pkg::*;
#(
  parameter int NQ          = 4,
  parameter int QDEPTH      = 16,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  cache_read_sched_if.slave    sched_io
);

  localparam int WIN_W = (NQ > 1) ? $clog2(NQ) : 1;
  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int FC_W  = $clog2(QDEPTH) + 1;

  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [31:0]      issue_cnt_q, issue_cnt_d;
  logic             ovf_q, ovf_d;
  logic             tmo_q, tmo_d;

  logic [NQ-1:0]       q_wr, q_rd, q_full, q_empty, q_elig;
  logic [ID_W-1:0]     q_head [NQ];
  logic [FC_W-1:0]     q_cnt  [NQ];
  logic [NQ*CNT_W-1:0] q_count_pk;
  logic [WIN_W-1:0]    winner;
  logic                pop, pri_oob, ovf_hit;

  function automatic logic [WIN_W-1:0] pick_winner(input logic [NQ-1:0] elig);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < NQ; i++) begin
      if (elig[i]) w = WIN_W'(i);
    end
    return w;
  endfunction

  for (genvar gi = 0; gi < NQ; gi++) begin : g_q
    sched_id_fifo #(.DEPTH(QDEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_i      (q_wr[gi]),
      .wr_data_i (sched_io.in_desc_id),
      .rd_i      (q_rd[gi]),
      .rd_data_o (q_head[gi]),
      .full_o    (q_full[gi]),
      .empty_o   (q_empty[gi]),
      .count_o   (q_cnt[gi])
    );
  end

  // Queue routing, arbitration and overflow detection
  assign q_elig  = ~q_empty & sched_io.in_q_enable;
  assign winner  = pick_winner(q_elig);
  assign pop     = (state_q == ST_IDLE) && sched_io.in_tx_ready && (|q_elig);
  assign pri_oob = (int'(sched_io.in_desc_pri) >= NQ);
  assign ovf_hit = sched_io.in_desc_wr && (pri_oob || (|(q_wr & q_full & ~q_rd)));

  always_comb begin
    q_wr       = '0;
    q_rd       = '0;
    q_count_pk = '0;
    for (int i = 0; i < NQ; i++) begin
      q_wr[i] = sched_io.in_desc_wr && (int'(sched_io.in_desc_pri) == i);
      q_rd[i] = pop && (int'(winner) == i);
      q_count_pk[CNT_W*i +: CNT_W] = CNT_W'(q_cnt[i]);
    end
  end

  // Scheduler FSM next state
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    id_d        = id_q;
    issue_cnt_d = issue_cnt_q;
    ovf_d       = ovf_q | ovf_hit;
    tmo_d       = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (pop) begin
          id_d    = q_head[winner];
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        issue_cnt_d = issue_cnt_q + 32'd1;
        state_d     = ST_WAIT_EOP;
      end
      ST_WAIT_EOP: begin
        if (sched_io.in_cache_eop) begin
          timer_d = '0;
          state_d = ST_IDLE;
        end else if (timer_q == TMR_W'(TIMEOUT_CYC - 1)) begin
          timer_d = '0;
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      id_q        <= '0;
      issue_cnt_q <= '0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      id_q        <= id_d;
      issue_cnt_q <= issue_cnt_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end

  assign sched_io.out_cache_id    = id_q;
  assign sched_io.out_cache_id_wr = (state_q == ST_ISSUE);
  assign sched_io.out_busy        = (state_q != ST_IDLE);
  assign sched_io.out_issue_cnt   = issue_cnt_q;
  assign sched_io.out_ovf_err     = ovf_q;
  assign sched_io.out_timeout_err = tmo_q;
  assign sched_io.out_q_count     = q_count_pk;

endmodule

// File: tb/tb_cache_read_sched.sv
module tb_cache_read_sched;
  import cache_read_sched_pkg::*;

  localparam int NQ     = 4;
  localparam int QDEPTH = 16;
  localparam int TMO    = 8;
  localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_read_sched_if #(.NQ(NQ)) sif ();

  cache_read_sched #(.NQ(NQ), .QDEPTH(QDEPTH), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .sched_io (sif.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Behavioural model: per-priority queues, one outstanding read.
  logic [7:0]  mq [NQ][$];
  int          m_mode = M_IDLE;
  logic [7:0]  m_id = '0;
  int          m_waited = 0;
  logic [31:0] m_cnt = '0;
  bit          m_ovf = 1'b0, m_tmo = 1'b0;

  always @(posedge clk) begin : model
    int popq;
    int pri;
    popq = -1;
    if (rst) begin
      for (int i = 0; i < NQ; i++) mq[i].delete();
      m_mode = M_IDLE; m_id = '0; m_waited = 0; m_cnt = '0; m_ovf = 1'b0; m_tmo = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (sif.in_tx_ready) begin
          for (int i = NQ - 1; i >= 0; i--) begin
            if (popq < 0 && mq[i].size() > 0 && sif.in_q_enable[i]) begin
              m_id = mq[i].pop_front();
              popq = i;
              m_mode = M_ISSUE;
            end
          end
        end
        M_ISSUE: begin
          m_cnt = m_cnt + 1;
          m_waited = 0;
          m_mode = M_WAIT;
        end
        default: begin
          if (sif.in_cache_eop) m_mode = M_IDLE;
          else begin
            m_waited++;
            if (m_waited == TMO) begin
              m_mode = M_IDLE;
              m_tmo = 1'b1;
            end
          end
        end
      endcase
      if (sif.in_desc_wr) begin
        pri = int'(sif.in_desc_pri);
        if (pri >= NQ) m_ovf = 1'b1;
        else if (mq[pri].size() >= QDEPTH) m_ovf = 1'b1;
        else mq[pri].push_back(sif.in_desc_id);
      end
    end
  end

  always @(negedge clk) begin : cmp
    logic [NQ*5-1:0] exp_cnt;
    if (cmp_en) begin
      exp_cnt = '0;
      for (int i = 0; i < NQ; i++) exp_cnt[5*i +: 5] = 5'(mq[i].size());
      chk("busy",      sif.out_busy,        64'(m_mode != M_IDLE));
      chk("id_wr",     sif.out_cache_id_wr, 64'(m_mode == M_ISSUE));
      chk("cache_id",  sif.out_cache_id,    m_id);
      chk("issue_cnt", sif.out_issue_cnt,   m_cnt);
      chk("q_count",   sif.out_q_count,     exp_cnt);
      chk("ovf_err",   sif.out_ovf_err,     m_ovf);
      chk("tmo_err",   sif.out_timeout_err, m_tmo);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [7:0] id, input logic [1:0] pri);
    sif.in_desc_wr = 1'b1; sif.in_desc_id = id; sif.in_desc_pri = pri;
    cyc();
    sif.in_desc_wr = 1'b0;
  endtask

  task automatic eop();
    sif.in_cache_eop = 1'b1;
    cyc();
    sif.in_cache_eop = 1'b0;
  endtask

  task automatic wait_issue(output logic [7:0] id, input int budget);
    bit seen;
    seen = 1'b0;
    id = 8'hxx;
    for (int k = 0; k < budget && !seen; k++) begin
      if (sif.out_cache_id_wr) begin
        seen = 1'b1;
        id = sif.out_cache_id;
      end else cyc();
    end
    chk("issue_seen", seen, 1);
  endtask

  task automatic serve(output logic [7:0] id);
    wait_issue(id, 20);
    cyc(2);
    eop();
  endtask

  initial begin : stim
    logic [7:0] id;
    sif.in_desc_wr = 1'b0; sif.in_desc_id = '0; sif.in_desc_pri = '0;
    sif.in_q_enable = 4'hF; sif.in_tx_ready = 1'b0; sif.in_cache_eop = 1'b0;
    cyc(2);
    cmp_en = 1'b1;
    chk("rst_busy", sif.out_busy, 0);
    chk("rst_cnt", sif.out_issue_cnt, 0);
    chk("rst_qcount", sif.out_q_count, 0);
    chk("rst_id", sif.out_cache_id, 0);
    rst = 1'b0;

    // Single descriptor: request two cycles after the write
    sif.in_tx_ready = 1'b1;
    put(8'h05, 2'd1);
    chk("t1_no_wr_yet", sif.out_cache_id_wr, 0);
    cyc();
    chk("t1_wr", sif.out_cache_id_wr, 1);
    chk("t1_id", sif.out_cache_id, 8'h05);
    cyc();
    chk("t1_wr_pulse", sif.out_cache_id_wr, 0);
    chk("t1_cnt", sif.out_issue_cnt, 1);
    chk("t1_id_hold", sif.out_cache_id, 8'h05);
    cyc(2);
    chk("t1_busy", sif.out_busy, 1);
    eop();
    chk("t1_idle", sif.out_busy, 0);

    // Strict priority ordering
    sif.in_tx_ready = 1'b0;
    put(8'h10, 2'd0); put(8'h20, 2'd3); put(8'h30, 2'd2);
    chk("t2_qcount", sif.out_q_count, {5'd1, 5'd1, 5'd0, 5'd1});
    sif.in_tx_ready = 1'b1;
    serve(id); chk("t2_first", id, 8'h20);
    serve(id); chk("t2_second", id, 8'h30);
    serve(id); chk("t2_third", id, 8'h10);
    chk("t2_cnt", sif.out_issue_cnt, 4);

    // Disabled queue holds its entry until enabled
    sif.in_q_enable = 4'b1110;
    put(8'h40, 2'd0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_disabled", sif.out_cache_id_wr, 0);
      cyc();
    end
    sif.in_q_enable = 4'hF;
    cyc();
    chk("t3_wr", sif.out_cache_id_wr, 1);
    chk("t3_id", sif.out_cache_id, 8'h40);
    cyc(2);
    eop();

    // Overflow on the 17th write, FIFO order preserved
    sif.in_tx_ready = 1'b0;
    for (int k = 0; k < 17; k++) put(8'h80 + 8'(k), 2'd2);
    chk("t4_q2_full", sif.out_q_count[14:10], 16);
    chk("t4_ovf", sif.out_ovf_err, 1);
    sif.in_tx_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      serve(id);
      chk("t4_order", id, 8'h80 + 8'(k));
    end
    chk("t4_empty", sif.out_q_count, 0);

    // Timeout with no eop, then the next queued ID goes out
    sif.in_tx_ready = 1'b0;
    put(8'hA1, 2'd1); put(8'hA2, 2'd1);
    sif.in_tx_ready = 1'b1;
    wait_issue(id, 10);
    chk("t5_first", id, 8'hA1);
    cyc(8);
    chk("t5_still_busy", sif.out_busy, 1);
    chk("t5_no_tmo_yet", sif.out_timeout_err, 0);
    cyc();
    chk("t5_idle", sif.out_busy, 0);
    chk("t5_tmo", sif.out_timeout_err, 1);
    cyc();
    chk("t5_next_wr", sif.out_cache_id_wr, 1);
    chk("t5_next_id", sif.out_cache_id, 8'hA2);
    cyc(2);
    eop();

    // Reset while waiting for eop with three queued
    put(8'hB0, 2'd3);
    wait_issue(id, 10);
    chk("t6_issue", id, 8'hB0);
    sif.in_tx_ready = 1'b0;
    cyc();
    put(8'hB1, 2'd0); put(8'hB2, 2'd1); put(8'hB3, 2'd2);
    chk("t6_busy_before", sif.out_busy, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_busy", sif.out_busy, 0);
    chk("t6_qcount", sif.out_q_count, 0);
    chk("t6_cnt", sif.out_issue_cnt, 0);
    chk("t6_id", sif.out_cache_id, 0);
    chk("t6_ovf", sif.out_ovf_err, 0);
    chk("t6_tmo", sif.out_timeout_err, 0);
    sif.in_tx_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 2) sif.in_cache_eop = 1'b1;
      else sif.in_cache_eop = 1'b0;
      cyc();
      chk("t6_no_issue", sif.out_cache_id_wr, 0);
    end
    sif.in_cache_eop = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
